stop_watch_lap: RTL and testbench
=================================

# stop_watch_lap

Parametrised successor to the clock's stopwatch: run/stop/clear controller, cascaded time counter and a lap memory that holds `LAP_DEPTH` split times. Stored laps can be recalled one at a time while stopped. It sits between the button debouncers and the MUX_FND display path. Its time outputs use the same field formats as the existing stopwatch, so the display mux needs no changes.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency.
- `TICK_HZ`, 100, frequency of the `omSec` increment. `DIV = CLK_HZ/TICK_HZ` and must be ≥ 2.
- `LAP_DEPTH`, 8, number of lap records. Must be ≥ 2.
- `HOUR_MAX`, 24, hour modulus, range 2..32.

Ports:
- `iClk` in 1: the single clock.
- `iRst` in 1: reset, synchronous, active-high.
- `iStop_Watch` in 1: mode select. Buttons act only while this is high. Counting continues regardless.
- `iBtn_L` in 1: run/stop. Single-cycle pulse from the debouncer.
- `iBtn_R` in 1: clear when stopped or viewing; lap when running. Single-cycle pulse.
- `iBtn_U` in 1: lap recall step. Single-cycle pulse.
- `omSec` out 7: hundredths of a second, 0..99.
- `oSec` out 6: seconds, 0..59.
- `oMin` out 6: minutes, 0..59.
- `oHour` out 5: hours, 0..`HOUR_MAX`-1.
- `oRun` out 1: high in RUN.
- `oView_Lap` out 1: high while the time outputs show a stored lap.
- `oLap_Idx` out clog2(`LAP_DEPTH`): displayed lap position, 0 = oldest.
- `oLap_Cnt` out clog2(`LAP_DEPTH`+1): number of stored laps.
- `oLap_Full` out 1: `oLap_Cnt` == `LAP_DEPTH`.

## Operation
- FSM states: IDLE, RUN, STOP, VIEW. Button pulses are effective only when `iStop_Watch` = 1.
- IDLE:
  - L → RUN.
  - R and U are ignored.
- RUN:
  - L → STOP.
  - R → capture a lap and stay in RUN.
  - U is ignored.
- STOP:
  - L → RUN.
  - R → IDLE, clearing time, divider, lap buffer and counts.
  - U with `oLap_Cnt` > 0 → VIEW with index 0 (the oldest lap). U with `oLap_Cnt` = 0 is ignored.
- VIEW:
  - U → index + 1. If the index was `oLap_Cnt`-1, go to STOP instead (live display).
  - L → RUN with live display.
  - R → IDLE, full clear.
- Simultaneous pulses: priority is R > L > U. Only one action is taken per cycle.
- Divider: counts only in RUN and holds its value in STOP/VIEW. On reaching `DIV`-1 it returns to 0 and issues a tick.
- Time cascade on tick:
  - `omSec` 99→0 carries into `oSec`.
  - 59→0 carries into `oMin`.
  - 59→0 carries into `oHour`.
  - `HOUR_MAX`-1 → 0 (full wrap to all zero, no flag).
- Lap record is 24 bits: {hour, min, sec, msec}. It holds the registered live time of the press cycle. If a tick occurs in the same cycle, the record takes the pre-increment value.
- Display mux: live time in IDLE/RUN/STOP, lap[index] in VIEW. `oLap_Idx` = 0 outside VIEW.

## Timing
- All outputs are registered. Their reset value is 0, and the state is IDLE.
- Button pulse in cycle n → state, `oRun`, `oView_Lap`, the displayed time and `oLap_Cnt` update in cycle n+1.
- After RUN becomes active in cycle n, the first `omSec` increment is visible in cycle n+`DIV`.
- The lap write and the `oLap_Cnt` update are visible in cycle n+1. That lap is recallable from cycle n+1.
- `iRst` overrides everything in the same edge, including mid-run and while in VIEW. The buffer contents are invalidated via `oLap_Cnt` = 0.

## Configuration
- Macro: `SW_LAP_OVERWRITE_EN`. It only changes behaviour when the buffer is full.
- Defined: a lap press when full overwrites the oldest record and the write pointer wraps. `oLap_Cnt` stays at `LAP_DEPTH` and `oLap_Full` stays high. VIEW index 0 is the oldest surviving lap.
- Undefined: a lap press when full is dropped, with no state change. `oLap_Full` stays high.

## Test plan
Sim parameters: `CLK_HZ`=1000, `TICK_HZ`=100 (`DIV`=10), `LAP_DEPTH`=4, `HOUR_MAX`=2.

- Reset, then L pulse, then 1000 cycles → `oSec`=1, `omSec`=0, `oRun`=1. L pulse → counting freezes. After 50 more cycles the values are unchanged.
- Force run to 1:59:59.99, then one tick → all time outputs 0, `oRun` still 1.
- R pulse in RUN in the same cycle as a tick, with time at 0:00:03.41 → lap[0] = 0:00:03.41, `oLap_Cnt`=1. Live display shows 03.42.
- Five laps → without the macro: `oLap_Cnt`=4, `oLap_Full`=1, recall shows laps 1–4. With the macro: recall shows laps 2–5.
- In STOP with 3 laps: U ×3 → `oLap_Idx` 0,1,2 with `oView_Lap`=1. The 4th U → live display, state STOP. U then R → IDLE, all outputs 0.
- `iStop_Watch`=0 while running → L/R/U ignored and counting continues. `iRst` mid-run → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/stop_watch_lap.sv
// Stopwatch with run/stop/clear control, cascaded time counter and a LAP_DEPTH-entry lap memory.
// Build option SW_LAP_OVERWRITE_EN: a lap press on a full buffer replaces the oldest lap.
module stop_watch_lap #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 8,
  parameter int HOUR_MAX  = 24
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iStop_Watch,
  input  logic                           iBtn_L,
  input  logic                           iBtn_R,
  input  logic                           iBtn_U,
  output logic [6:0]                     omSec,
  output logic [5:0]                     oSec,
  output logic [5:0]                     oMin,
  output logic [4:0]                     oHour,
  output logic                           oRun,
  output logic                           oView_Lap,
  output logic [$clog2(LAP_DEPTH)-1:0]   oLap_Idx,
  output logic [$clog2(LAP_DEPTH+1)-1:0] oLap_Cnt,
  output logic                           oLap_Full
);
  // state  | meaning
  // IDLE   | cleared, waiting for run
  // RUN    | counting, R captures laps
  // STOP   | frozen, live display
  // VIEW   | frozen, displaying lap[idx]
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [1:0] S_VIEW = 2'd3;

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(LAP_DEPTH);
  localparam int CW  = $clog2(LAP_DEPTH + 1);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [23:0]   time_q, time_d;   // {hour, min, sec, msec}
  logic [23:0]   disp_q, disp_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, view_q, full_q;
  logic          tick, lap_we, clear;
  logic          btn_l, btn_r, btn_u;
  logic [IW-1:0] oldest, rd_idx;
  logic [IW:0]   rd_sum;
  logic [23:0]   lap_mem [LAP_DEPTH];

  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [4:0] h;
    logic [5:0] m, s;
    logic [6:0] ms;
    {h, m, s, ms} = t;
    if (ms != 7'd99) ms = ms + 7'd1;
    else begin
      ms = '0;
      if (s != 6'd59) s = s + 6'd1;
      else begin
        s = '0;
        if (m != 6'd59) m = m + 6'd1;
        else begin
          m = '0;
          h = (h == 5'(HOUR_MAX - 1)) ? 5'd0 : h + 5'd1;
        end
      end
    end
    return {h, m, s, ms};
  endfunction

  assign btn_l = iStop_Watch & iBtn_L;
  assign btn_r = iStop_Watch & iBtn_R;
  assign btn_u = iStop_Watch & iBtn_U;
  assign tick  = (state_q == S_RUN) && (div_q == DW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    time_d  = time_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    lap_we  = 1'b0;
    clear   = 1'b0;
    if (state_q == S_RUN) begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) time_d = time_inc(time_q);
    end
    case (state_q)
      S_IDLE: if (btn_l) state_d = S_RUN;
      S_RUN: begin
        if (btn_r) begin
          if (!full_q) begin
            lap_we = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
`ifdef SW_LAP_OVERWRITE_EN
          else lap_we = 1'b1;
`else
          else lap_we = 1'b0;
`endif
          if (lap_we) wr_d = (wr_q == IW'(LAP_DEPTH - 1)) ? '0 : wr_q + IW'(1);
        end else if (btn_l) state_d = S_STOP;
      end
      S_STOP: begin
        if (btn_r) clear = 1'b1;
        else if (btn_l) state_d = S_RUN;
        else if (btn_u && cnt_q != '0) begin
          state_d = S_VIEW;
          idx_d   = '0;
        end
      end
      S_VIEW: begin
        if (btn_r) clear = 1'b1;
        else if (btn_l) begin
          state_d = S_RUN;
          idx_d   = '0;
        end else if (btn_u) begin
          if (CW'(idx_q) == cnt_q - CW'(1)) begin
            state_d = S_STOP;
            idx_d   = '0;
          end else idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      div_d   = '0;
      time_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
      wr_d    = '0;
    end
  end

  // Once full, the write pointer sits on the oldest surviving record.
  assign oldest = full_q ? wr_q : '0;

  always_comb begin
    rd_sum = {1'b0, oldest} + {1'b0, idx_d};
    if (rd_sum >= (IW+1)'(LAP_DEPTH)) rd_sum = rd_sum - (IW+1)'(LAP_DEPTH);
    rd_idx = rd_sum[IW-1:0];
    disp_d = (state_d == S_VIEW) ? lap_mem[rd_idx] : time_d;
  end

  always_ff @(posedge iClk) begin
    if (!iRst && lap_we) lap_mem[wr_q] <= time_q;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      time_q  <= '0;
      disp_q  <= '0;
      idx_q   <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      view_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      time_q  <= time_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      run_q   <= (state_d == S_RUN);
      view_q  <= (state_d == S_VIEW);
      full_q  <= (cnt_d == CW'(LAP_DEPTH));
    end
  end

  assign omSec     = disp_q[6:0];
  assign oSec      = disp_q[12:7];
  assign oMin      = disp_q[18:13];
  assign oHour     = disp_q[23:19];
  assign oRun      = run_q;
  assign oView_Lap = view_q;
  assign oLap_Idx  = idx_q;
  assign oLap_Cnt  = cnt_q;
  assign oLap_Full = full_q;
endmodule

// File: tb/tb_stop_watch_lap.sv
// Directed bench for stop_watch_lap with DIV=10, LAP_DEPTH=4, HOUR_MAX=2.
module tb_stop_watch_lap;
  logic iClk = 1'b0;
  logic iRst, iStop_Watch, iBtn_L, iBtn_R, iBtn_U;
  logic [6:0] omSec;
  logic [5:0] oSec, oMin;
  logic [4:0] oHour;
  logic       oRun, oView_Lap, oLap_Full;
  logic [1:0] oLap_Idx;
  logic [2:0] oLap_Cnt;

  int checks = 0;
  int errors = 0;

  stop_watch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(4), .HOUR_MAX(2)) dut (
    .iClk(iClk), .iRst(iRst), .iStop_Watch(iStop_Watch),
    .iBtn_L(iBtn_L), .iBtn_R(iBtn_R), .iBtn_U(iBtn_U),
    .omSec(omSec), .oSec(oSec), .oMin(oMin), .oHour(oHour),
    .oRun(oRun), .oView_Lap(oView_Lap), .oLap_Idx(oLap_Idx),
    .oLap_Cnt(oLap_Cnt), .oLap_Full(oLap_Full)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int sw, l, r, u;
    int run, view, idx, cnt, full;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic logic [23:0] tm_now();
    return {oHour, oMin, oSec, omSec};
  endfunction

  function automatic logic [23:0] t(input int h, input int m, input int s, input int ms);
    return {5'(h), 6'(m), 6'(s), 7'(ms)};
  endfunction

  function automatic logic [7:0] status();
    return {oRun, oView_Lap, oLap_Idx, oLap_Cnt, oLap_Full};
  endfunction

  function automatic logic [7:0] st(input int run, input int view, input int idx,
                                    input int cnt, input int full);
    return {1'(run), 1'(view), 2'(idx), 3'(cnt), 1'(full)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic press(input logic l, input logic r, input logic u);
    iBtn_L = l; iBtn_R = r; iBtn_U = u;
    @(negedge iClk);
    iBtn_L = 1'b0; iBtn_R = 1'b0; iBtn_U = 1'b0;
  endtask

  task automatic do_reset();
    iRst = 1'b1; iStop_Watch = 1'b1;
    iBtn_L = 1'b0; iBtn_R = 1'b0; iBtn_U = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_ms;
    //           sw l r u   run view idx cnt full
    vecs[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 0,  0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 1,  0, 0, 0, 0, 0};
    vecs[3]  = '{1, 1, 0, 0,  1, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 1, 0,  1, 0, 0, 1, 0};
    vecs[5]  = '{1, 0, 1, 0,  1, 0, 0, 2, 0};
    vecs[6]  = '{1, 0, 1, 0,  1, 0, 0, 3, 0};
    vecs[7]  = '{1, 1, 0, 0,  0, 0, 0, 3, 0};
    vecs[8]  = '{1, 0, 0, 1,  0, 1, 0, 3, 0};
    vecs[9]  = '{1, 0, 0, 1,  0, 1, 1, 3, 0};
    vecs[10] = '{1, 0, 0, 1,  0, 1, 2, 3, 0};
    vecs[11] = '{1, 0, 0, 1,  0, 0, 0, 3, 0};
    vecs[12] = '{1, 0, 0, 1,  0, 1, 0, 3, 0};
    vecs[13] = '{1, 0, 1, 0,  0, 0, 0, 0, 0};
    vecs[14] = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
    vecs[15] = '{1, 1, 0, 0,  1, 0, 0, 0, 0};
    vecs[16] = '{1, 1, 1, 0,  1, 0, 0, 1, 0};
    vecs[17] = '{1, 1, 0, 0,  0, 0, 0, 1, 0};
    vecs[18] = '{1, 1, 0, 1,  1, 0, 0, 1, 0};
    vecs[19] = '{1, 1, 0, 0,  0, 0, 0, 1, 0};
    vecs[20] = '{1, 0, 0, 1,  0, 1, 0, 1, 0};
    vecs[21] = '{1, 1, 0, 0,  1, 0, 0, 1, 0};
    vecs[22] = '{1, 1, 0, 0,  0, 0, 0, 1, 0};
    vecs[23] = '{1, 0, 0, 1,  0, 1, 0, 1, 0};
    vecs[24] = '{1, 0, 1, 1,  0, 0, 0, 0, 0};

    // Button/FSM table; every run stretch is shorter than one tick so time stays zero.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      iStop_Watch = 1'(vecs[i].sw);
      press(1'(vecs[i].l), 1'(vecs[i].r), 1'(vecs[i].u));
      iStop_Watch = 1'b1;
      check($sformatf("vec%0d", i), {status(), tm_now()},
            {st(vecs[i].run, vecs[i].view, vecs[i].idx, vecs[i].cnt, vecs[i].full), 24'd0});
    end

    // First increment latency, one second of counting, then freeze.
    do_reset();
    press(1, 0, 0);
    idle(9);
    check("first_tick_early", {8'd0, tm_now()}, {8'd0, t(0, 0, 0, 0)});
    idle(1);
    check("first_tick", {8'd0, tm_now()}, {8'd0, t(0, 0, 0, 1)});
    idle(990);
    check("one_second", {status(), tm_now()}, {st(1, 0, 0, 0, 0), t(0, 0, 1, 0)});
    press(1, 0, 0);
    check("stop", {status(), tm_now()}, {st(0, 0, 0, 0, 0), t(0, 0, 1, 0)});
    idle(50);
    check("stop_hold", {status(), tm_now()}, {st(0, 0, 0, 0, 0), t(0, 0, 1, 0)});

    // Full wrap from the last representable time.
    force dut.time_q = {5'd1, 6'd59, 6'd59, 7'd99};
    #1 release dut.time_q;
    @(negedge iClk);
    press(1, 0, 0);
    check("wrap_pre", {status(), tm_now()}, {st(1, 0, 0, 0, 0), t(1, 59, 59, 99)});
    n = 0;
    while (omSec == 7'd99 && n < 20) begin
      @(negedge iClk);
      n++;
    end
    check("wrap_timeout", 32'(n < 20), 32'd1);
    check("wrap", {status(), tm_now()}, {st(1, 0, 0, 0, 0), t(0, 0, 0, 0)});

    // Lap press coinciding with a tick records the pre-increment time.
    do_reset();
    press(1, 0, 0);
    idle(3419);
    press(0, 1, 0);
    check("lap_tick_live", {status(), tm_now()}, {st(1, 0, 0, 1, 0), t(0, 0, 3, 42)});
    press(1, 0, 0);
    press(0, 0, 1);
    check("lap_tick_rec", {status(), tm_now()}, {st(0, 1, 0, 1, 0), t(0, 0, 3, 41)});

    // Five laps into a four-entry buffer, at 0.10 s steps.
    do_reset();
    press(1, 0, 0);
    for (int j = 1; j <= 5; j++) begin
      idle(j == 1 ? 104 : 99);
      press(0, 1, 0);
      if (j >= 4) check($sformatf("lap_full%0d", j), {24'd0, status()}, {24'd0, st(1, 0, 0, 4, 1)});
    end
    press(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
`ifdef SW_LAP_OVERWRITE_EN
      exp_ms = 10 * (k + 2);
`else
      exp_ms = 10 * (k + 1);
`endif
      press(0, 0, 1);
      check($sformatf("recall%0d", k), {status(), tm_now()}, {st(0, 1, k, 4, 1), t(0, 0, 0, exp_ms)});
    end
    press(0, 0, 1);
    check("recall_exit", {status(), tm_now()}, {st(0, 0, 0, 4, 1), t(0, 0, 0, 50)});

    // Mode select low: buttons ignored, counting continues; then reset mid-run.
    do_reset();
    press(1, 0, 0);
    iStop_Watch = 1'b0;
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    iStop_Watch = 1'b1;
    check("mode_off", {24'd0, status()}, {24'd0, st(1, 0, 0, 0, 0)});
    idle(7);
    check("mode_off_count", {8'd0, tm_now()}, {8'd0, t(0, 0, 0, 1)});
    iRst = 1'b1;
    @(negedge iClk);
    check("reset_midrun", {status(), tm_now()}, 32'd0);
    iRst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
